// File: rtl/mult_share_ctrl_if.sv
// Operand/result bus for the shared multiplier controller.
// Two requester handshakes plus one result handshake.
interface mult_share_ctrl_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_ready;
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] res_data;
    logic               res_id;
    logic               res_ready;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin shared shift-and-add multiplier for two requesters.
// Optional macro MULT_ZERO_SKIP_EN: zero operands finish in one edge.
module mult_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_ctrl_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic             prio;
    logic             grant;
    logic             accept;
    logic             res_id_q;
    logic             res_valid_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_valid;

    // Pick the lone valid requester, else fall back to priority holder.
    always_comb begin
        grant = prio;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
        sel_a     = grant ? bus.req1_a : bus.req0_a;
        sel_b     = grant ? bus.req1_b : bus.req0_b;
        sel_valid = grant ? bus.req1_valid : bus.req0_valid;
        accept    = (state == IDLE) && !rst && sel_valid;
    end

    assign bus.req0_ready = (state == IDLE) && !grant && !rst;
    assign bus.req1_ready = (state == IDLE) && grant && !rst;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = acc;
    assign bus.res_id     = res_id_q;

    // Sequencer: accept, iterate WIDTH steps, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand    <= PW'(sel_a);
                        mplier   <= sel_b;
                        acc      <= '0;
                        cnt      <= '0;
                        res_id_q <= grant;
`ifdef MULT_ZERO_SKIP_EN
                        if ((sel_a == '0) || (sel_b == '0)) begin
                            state       <= DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        prio        <= ~res_id_q;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing and arbitration controller that shares one iterative shift-and-add multiplier datapath between two requesters. Each requester hands over a pair of unsigned operands through a valid/ready handshake. The block grants the datapath round-robin, runs the partial-product accumulation over WIDTH cycles, and returns the full-width product tagged with the requester ID through a valid/ready result port. It sits between the operand sources and the downstream result consumer, replacing per-requester combinational multipliers.

## Interface
- WIDTH, default 4: operand width in bits; the product is 2*WIDTH bits.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 holds a valid operand pair.
- req0_a, req0_b  in  WIDTH each  requester 0 operands (unsigned).
- req0_ready  out  1  requester 0 operands accepted on this edge when req0_valid is also high.
- req1_valid, req1_a, req1_b, req1_ready: requester 1 equivalents of the req0 ports.
- res_valid  out  1  result available.
- res_data  out  2*WIDTH  product a*b.
- res_id  out  1  ID of the requester that owns res_data (0 or 1).
- res_ready  in  1  consumer accepts the result.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - reqN_ready = (state==IDLE) && grant==N && !rst. Ready is combinational from the registered state and the grant.
  - grant selects the only valid requester. If both are valid, grant selects the requester holding priority.
  - On the accept edge:
    - Latch multiplicand = a, zero-extended to 2*WIDTH.
    - Latch multiplier = b.
    - Clear the accumulator and the step counter.
    - Record res_id.
    - Go to RUN.
- **RUN**, one step per clock:
  - If multiplier[0]==1, the accumulator adds the multiplicand.
  - The multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - The step counter increments.
  - After step WIDTH the accumulator holds a*b. Go to DONE.
- **DONE**
  - res_valid=1 and res_data=accumulator.
  - res_data and res_id are held stable until the edge where res_valid&&res_ready.
  - On that edge, go to IDLE and give priority to the requester not just served.
- Arithmetic: unsigned throughout. The accumulator is 2*WIDTH bits wide, so no overflow is possible; the maximum is (2^WIDTH-1)^2.
- Requester side:
  - Operands are sampled only on the accept edge.
  - Changing a/b or dropping valid at any other time has no effect.
  - A requester that is not granted waits with valid held high and is not dropped.
- Reset values:
  - state=IDLE, priority=requester 0.
  - res_valid=0, res_data=0, res_id=0.
  - req0_ready=0 and req1_ready=0 while rst is high.
  - Accumulator, multiplicand, multiplier and counter all 0.
- Reset mid-operation, in RUN or DONE: the in-flight product is discarded with no result emitted. The next cycle is IDLE with priority set to requester 0.

## Timing
- Accept edge E0. RUN step edges E1..EWIDTH. res_valid is high in the cycle after EWIDTH, so the latency is WIDTH edges from accept to res_valid.
- With res_ready held high:
  - DONE lasts 1 cycle.
  - IDLE lasts 1 cycle; ready is visible in it.
  - The next accept happens at E(WIDTH+2), giving a sustained throughput of one product per WIDTH+2 cycles.
- Simultaneous valid from both requesters: exactly one ready is asserted, never both.
- Backpressure: DONE persists for any number of cycles while res_ready=0. No new operands are accepted during that time.

## Configuration
- MULT_ZERO_SKIP_EN defined:
  - If the selected a==0 or b==0 at the accept edge, go directly from IDLE to DONE with the accumulator cleared to 0.
  - Latency is then 1 edge.
  - Nonzero operands follow the normal WIDTH-step path.
- MULT_ZERO_SKIP_EN not defined: every operand pair, including zero operands, takes the full WIDTH steps.

## Test plan
- Single request:
  - Stimulus: reset, then req0 6*6 with res_ready=1.
  - Required response: req0_ready high in the first IDLE cycle; res_valid exactly 4 edges after accept with res_data=36 and res_id=0; deasserts after 1 cycle.
- Contention:
  - Stimulus: req0 7*5 and req1 7*7 valid in the same cycle, both held.
  - Required response: first result 35 with id 0, then 49 with id 1.
  - Follow-up: a second round with both valid again serves req0 first (priority returns to req0 after req1 is served).
- Backpressure:
  - Stimulus: req1 5*5 with res_ready=0 for 6 cycles after res_valid rises.
  - Required response: res_data=25 and res_id=1 held stable; both readys stay 0; the result is released on the res_ready edge.
- Width bound:
  - Stimulus: 15*15, then 2*6, back-to-back on req0.
  - Required response: 225, then 12; the second accept occurs exactly WIDTH+2 edges after the first.
- Reset mid-RUN:
  - Stimulus: assert rst 2 edges after accepting 4*6.
  - Required response: no res_valid; outputs return to 0; a following req1 7*3 produces 21 with id 1.
- Zero skip:
  - Stimulus: req0 0*9.
  - Required response with MULT_ZERO_SKIP_EN: res_valid 1 edge after accept, res_data=0.
  - Required response without the macro: res_valid after 4 edges, res_data=0.
